reg_writer: RTL and testbench

REG_WRITER -- requirements
Module: reg_writer

---
 rtl/reg_writer.sv | 135 +++++++++++++
 tb/tb_reg_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writer.sv
// Register-file write-back arbiter: merges ALU, load and mul/div results into
// one write port (ALU > MEM > MDU) and tracks pending writes per register.
module reg_writer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic [31:0]     busy,
  output logic            we,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata
);

  logic            hold_mem_v_q, hold_mem_v_d;
  logic [4:0]      hold_mem_rd_q, hold_mem_rd_d;
  logic [XLEN-1:0] hold_mem_data_q, hold_mem_data_d;
  logic            hold_mdu_v_q, hold_mdu_v_d;
  logic [4:0]      hold_mdu_rd_q, hold_mdu_rd_d;
  logic [XLEN-1:0] hold_mdu_data_q, hold_mdu_data_d;
  logic            we_q, we_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [31:0]     busy_q, busy_d;

  logic            alu_req, mem_req, mdu_req;
  logic            mem_gnt, mdu_gnt;
  logic [4:0]      mem_src_rd, mdu_src_rd;
  logic [XLEN-1:0] mem_src_data, mdu_src_data;

  assign mem_ready = rst_n & ~hold_mem_v_q;
  assign mdu_ready = rst_n & ~hold_mdu_v_q;

  // A held beat always takes precedence over the input: ready is low while held.
  assign mem_src_rd   = hold_mem_v_q ? hold_mem_rd_q   : mem_rd;
  assign mem_src_data = hold_mem_v_q ? hold_mem_data_q : mem_data;
  assign mdu_src_rd   = hold_mdu_v_q ? hold_mdu_rd_q   : mdu_rd;
  assign mdu_src_data = hold_mdu_v_q ? hold_mdu_data_q : mdu_data;

  // Beats to x0 are accepted but never raise a request.
  assign alu_req = alu_valid & (alu_rd != 5'd0);
  assign mem_req = hold_mem_v_q | (mem_valid & mem_ready & (mem_rd != 5'd0));
  assign mdu_req = hold_mdu_v_q | (mdu_valid & mdu_ready & (mdu_rd != 5'd0));

  assign mem_gnt = mem_req & ~alu_req;
  assign mdu_gnt = mdu_req & ~alu_req & ~mem_req;

  always_comb begin
    we_d    = alu_req | mem_req | mdu_req;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_req) begin
      waddr_d = alu_rd;
      wdata_d = alu_data;
    end else if (mem_gnt) begin
      waddr_d = mem_src_rd;
      wdata_d = mem_src_data;
    end else if (mdu_gnt) begin
      waddr_d = mdu_src_rd;
      wdata_d = mdu_src_data;
    end
  end

  // Losing requests park in (or stay in) their holding slot; winners leave it.
  always_comb begin
    hold_mem_v_d    = mem_req & ~mem_gnt;
    hold_mem_rd_d   = hold_mem_rd_q;
    hold_mem_data_d = hold_mem_data_q;
    if (!hold_mem_v_q && mem_req && !mem_gnt) begin
      hold_mem_rd_d   = mem_rd;
      hold_mem_data_d = mem_data;
    end
    hold_mdu_v_d    = mdu_req & ~mdu_gnt;
    hold_mdu_rd_d   = hold_mdu_rd_q;
    hold_mdu_data_d = hold_mdu_data_q;
    if (!hold_mdu_v_q && mdu_req && !mdu_gnt) begin
      hold_mdu_rd_d   = mdu_rd;
      hold_mdu_data_d = mdu_data;
    end
  end

  // Clear first so a same-edge issue to the written register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (we_d)
      busy_d[waddr_d] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0))
      busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_mem_v_q    <= 1'b0;
      hold_mem_rd_q   <= '0;
      hold_mem_data_q <= '0;
      hold_mdu_v_q    <= 1'b0;
      hold_mdu_rd_q   <= '0;
      hold_mdu_data_q <= '0;
      we_q            <= 1'b0;
      waddr_q         <= '0;
      wdata_q         <= '0;
      busy_q          <= '0;
    end else begin
      hold_mem_v_q    <= hold_mem_v_d;
      hold_mem_rd_q   <= hold_mem_rd_d;
      hold_mem_data_q <= hold_mem_data_d;
      hold_mdu_v_q    <= hold_mdu_v_d;
      hold_mdu_rd_q   <= hold_mdu_rd_d;
      hold_mdu_data_q <= hold_mdu_data_d;
      we_q            <= we_d;
      waddr_q         <= waddr_d;
      wdata_q         <= wdata_d;
      busy_q          <= busy_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_reg_writer.sv
// Self-checking bench for reg_writer: directed vector table, hand-written
// reset/starvation sequences and a randomized run against a queue-based model.
module tb_reg_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, mdu_valid, iss_valid;
  logic [4:0]  alu_rd, mem_rd, mdu_rd, iss_rd;
  logic [31:0] alu_data, mem_data, mdu_data;
  logic        mem_ready, mdu_ready, we;
  logic [4:0]  waddr;
  logic [31:0] wdata, busy;

  int errors = 0;
  int checks = 0;

  reg_writer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy(busy),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  // Reference model: each source owns one slot; every request that loses
  // arbitration sits in its source slot, the first in priority order is written.
  typedef struct { logic [4:0] rd; logic [31:0] data; int src; } req_t;
  logic        m_mem_v, m_mdu_v, m_we;
  logic [4:0]  m_mem_rd, m_mdu_rd, m_waddr;
  logic [31:0] m_mem_data, m_mdu_data, m_wdata, m_busy;

  task automatic model_reset();
    m_mem_v = 0; m_mdu_v = 0; m_mem_rd = 0; m_mdu_rd = 0;
    m_mem_data = 0; m_mdu_data = 0;
    m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
  endtask

  task automatic model_step();
    req_t q[$];
    if (alu_valid && alu_rd != 0) q.push_back('{alu_rd, alu_data, 0});
    if (m_mem_v) q.push_back('{m_mem_rd, m_mem_data, 1});
    else if (mem_valid && mem_rd != 0) q.push_back('{mem_rd, mem_data, 1});
    if (m_mdu_v) q.push_back('{m_mdu_rd, m_mdu_data, 2});
    else if (mdu_valid && mdu_rd != 0) q.push_back('{mdu_rd, mdu_data, 2});
    m_we = (q.size() > 0);
    if (m_we) begin
      m_waddr = q[0].rd;
      m_wdata = q[0].data;
      m_busy[q[0].rd] = 1'b0;
    end
    m_mem_v = 0;
    m_mdu_v = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i].src == 1) begin m_mem_v = 1; m_mem_rd = q[i].rd; m_mem_data = q[i].data; end
      if (q[i].src == 2) begin m_mdu_v = 1; m_mdu_rd = q[i].rd; m_mdu_data = q[i].data; end
    end
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("model_we", {31'd0, we}, {31'd0, m_we});
    chk("model_waddr", {27'd0, waddr}, {27'd0, m_waddr});
    chk("model_wdata", wdata, m_wdata);
    chk("model_busy", busy, m_busy);
    chk("model_mem_ready", {31'd0, mem_ready}, {31'd0, ~m_mem_v});
    chk("model_mdu_ready", {31'd0, mdu_ready}, {31'd0, ~m_mdu_v});
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; mdu_valid = 0; iss_valid = 0;
    alu_rd = 0; mem_rd = 0; mdu_rd = 0; iss_rd = 0;
    alu_data = 0; mem_data = 0; mdu_data = 0;
  endtask

  typedef struct {
    logic       av; logic [4:0] ard; logic [31:0] ad;
    logic       mv; logic [4:0] mrd; logic [31:0] md;
    logic       dv; logic [4:0] drd; logic [31:0] dd;
    logic       iv; logic [4:0] ird;
    logic       e_we; logic [4:0] e_waddr; logic [31:0] e_wdata;
    logic       e_mr; logic e_dr; logic [31:0] e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic dv, input logic [4:0] drd, input logic [31:0] dd,
    input logic iv, input logic [4:0] ird,
    input logic e_we, input logic [4:0] e_waddr, input logic [31:0] e_wdata,
    input logic e_mr, input logic e_dr, input logic [31:0] e_busy);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.dv = dv; v.drd = drd; v.dd = dd; v.iv = iv; v.ird = ird;
    v.e_we = e_we; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_mr = e_mr; v.e_dr = e_dr; v.e_busy = e_busy;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    //            alu            mem              mdu            iss     we addr data    mr dr busy
    tbl[0]  = mk(1, 5, 32'h1234, 0, 0, 0,         0, 0, 0,       0, 0,   1, 5, 32'h1234, 1, 1, 32'h0);
    tbl[1]  = mk(0, 0, 0,        0, 0, 0,         0, 0, 0,       0, 0,   0, 5, 32'h1234, 1, 1, 32'h0);
    tbl[2]  = mk(1, 3, 32'hA,    1, 4, 32'hB,     1, 6, 32'hC,   0, 0,   1, 3, 32'hA,    0, 0, 32'h0);
    tbl[3]  = mk(0, 0, 0,        0, 0, 0,         0, 0, 0,       0, 0,   1, 4, 32'hB,    1, 0, 32'h0);
    tbl[4]  = mk(0, 0, 0,        0, 0, 0,         0, 0, 0,       0, 0,   1, 6, 32'hC,    1, 1, 32'h0);
    tbl[5]  = mk(0, 0, 0,        0, 0, 0,         0, 0, 0,       0, 0,   0, 6, 32'hC,    1, 1, 32'h0);
    tbl[6]  = mk(0, 0, 0,        1, 0, 32'hFFFF,  0, 0, 0,       0, 0,   0, 6, 32'hC,    1, 1, 32'h0);
    tbl[7]  = mk(0, 0, 0,        0, 0, 0,         1, 0, 32'hEE,  0, 0,   0, 6, 32'hC,    1, 1, 32'h0);
    tbl[8]  = mk(1, 0, 32'h55,   1, 0, 32'h66,    0, 0, 0,       0, 0,   0, 6, 32'hC,    1, 1, 32'h0);
    tbl[9]  = mk(0, 0, 0,        1, 8, 32'h77,    1, 9, 32'h88,  0, 0,   1, 8, 32'h77,   1, 0, 32'h0);
    tbl[10] = mk(0, 0, 0,        0, 0, 0,         0, 0, 0,       0, 0,   1, 9, 32'h88,   1, 1, 32'h0);
    tbl[11] = mk(0, 0, 0,        0, 0, 0,         0, 0, 0,       1, 7,   0, 9, 32'h88,   1, 1, 32'h80);
    tbl[12] = mk(1, 7, 32'h99,   0, 0, 0,         0, 0, 0,       0, 0,   1, 7, 32'h99,   1, 1, 32'h0);
    tbl[13] = mk(1, 7, 32'h9A,   0, 0, 0,         0, 0, 0,       1, 7,   1, 7, 32'h9A,   1, 1, 32'h80);
    tbl[14] = mk(0, 0, 0,        0, 0, 0,         0, 0, 0,       1, 0,   0, 7, 32'h9A,   1, 1, 32'h80);

    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_we", {31'd0, we}, 32'd0);
    chk("reset_waddr", {27'd0, waddr}, 32'd0);
    chk("reset_wdata", wdata, 32'd0);
    chk("reset_busy", busy, 32'd0);
    chk("reset_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("reset_mdu_ready", {31'd0, mdu_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_mem_ready", {31'd0, mem_ready}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].md;
      mdu_valid = tbl[i].dv; mdu_rd = tbl[i].drd; mdu_data = tbl[i].dd;
      iss_valid = tbl[i].iv; iss_rd = tbl[i].ird;
      step();
      chk($sformatf("vec%0d_we", i), {31'd0, we}, {31'd0, tbl[i].e_we});
      chk($sformatf("vec%0d_waddr", i), {27'd0, waddr}, {27'd0, tbl[i].e_waddr});
      chk($sformatf("vec%0d_wdata", i), wdata, tbl[i].e_wdata);
      chk($sformatf("vec%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, tbl[i].e_mr});
      chk($sformatf("vec%0d_mdu_ready", i), {31'd0, mdu_ready}, {31'd0, tbl[i].e_dr});
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
    end

    // Reset while a load to x9 is parked: it must never be written.
    idle();
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
    iss_valid = 1; iss_rd = 12;
    step();
    chk("midrst_held", {31'd0, mem_ready}, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_we", {31'd0, we}, 32'd0);
    chk("midrst_busy", busy, 32'd0);
    chk("midrst_mem_ready_low", {31'd0, mem_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("midrst_no_write", {31'd0, we}, 32'd0);
      chk("midrst_ready_back", {31'd0, mem_ready}, 32'd1);
    end
    mem_valid = 1; mem_rd = 13; mem_data = 32'h1313;
    step();
    chk("postrst_accept_we", {31'd0, we}, 32'd1);
    chk("postrst_accept_addr", {27'd0, waddr}, 32'd13);

    // Starvation: ALU every cycle keeps a parked load waiting.
    idle();
    mem_valid = 1; mem_rd = 10; mem_data = 32'h3;
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1; alu_rd = 5'($urandom_range(1, 31)); alu_data = $urandom;
      step();
      chk("starve_mem_ready", {31'd0, mem_ready}, 32'd0);
      chk("starve_alu_write", {27'd0, waddr}, {27'd0, alu_rd});
      mem_data = 32'hDEAD;
    end
    idle();
    step();
    chk("starve_release_we", {31'd0, we}, 32'd1);
    chk("starve_release_addr", {27'd0, waddr}, 32'd10);
    chk("starve_release_data", wdata, 32'h3);

    // Randomized traffic with narrow rd range to provoke collisions and x0 beats.
    for (int i = 0; i < 600; i++) begin
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      mem_valid = $urandom_range(0, 1);
      mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      mdu_valid = $urandom_range(0, 1);
      mdu_rd = 5'($urandom_range(0, 7)); mdu_data = $urandom;
      iss_valid = $urandom_range(0, 1);
      iss_rd = 5'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
